avgp_3x3_window_gen: RTL and testbench

Producer side of the 3x3 pooling-core window interface. Accepts a raster-scan pixel stream, one pixel per valid cycle, and emits nine parallel pixels forming each complete 3x3 window (stride 1, no padding) with a single valid strobe. Sits directly upstream of the 3x3 average-pool core and drives its pxl_in_00..08 and valid_in. Pixel data is opaque: fp32 bit patterns pass through untouched, with no arithmetic on them.

---
 rtl/avgp_3x3_window_gen.sv | 108 ++++++++++
 tb/tb_avgp_3x3_window_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/avgp_3x3_window_gen.sv
// 3x3 sliding-window generator for the average-pool core: turns a raster pixel
// stream into nine parallel window pixels with a one-cycle valid strobe.
module avgp_3x3_window_gen #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 33,
  parameter int IMAGE_HEIGHT = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic [DATA_WIDTH-1:0] pxl_out_00,
  output logic [DATA_WIDTH-1:0] pxl_out_01,
  output logic [DATA_WIDTH-1:0] pxl_out_02,
  output logic [DATA_WIDTH-1:0] pxl_out_03,
  output logic [DATA_WIDTH-1:0] pxl_out_04,
  output logic [DATA_WIDTH-1:0] pxl_out_05,
  output logic [DATA_WIDTH-1:0] pxl_out_06,
  output logic [DATA_WIDTH-1:0] pxl_out_07,
  output logic [DATA_WIDTH-1:0] pxl_out_08,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic [DATA_WIDTH-1:0] line1 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] line2 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] win_p0  [9];
  logic [DATA_WIDTH-1:0] win_nxt [9];
  logic [DATA_WIDTH-1:0] pxl_p1  [9];
  logic                  accept_p0;
  logic                  emit_p0;
  logic                  last_p0;

  // Stage p0: pixel acceptance; reset takes priority over a valid pixel
  assign accept_p0 = valid_in & ~reset;
  assign emit_p0   = accept_p0 && (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
  assign last_p0   = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

  // Window after this pixel: shift left, new right column from the delay lines
  always_comb begin
    win_nxt[0] = win_p0[1];
    win_nxt[1] = win_p0[2];
    win_nxt[2] = line2[IMAGE_WIDTH-1];
    win_nxt[3] = win_p0[4];
    win_nxt[4] = win_p0[5];
    win_nxt[5] = line1[IMAGE_WIDTH-1];
    win_nxt[6] = win_p0[7];
    win_nxt[7] = win_p0[8];
    win_nxt[8] = pixel_in;
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      line1[0] <= pixel_in;
      line2[0] <= line1[IMAGE_WIDTH-1];
      for (int i = 1; i < IMAGE_WIDTH; i++) begin
        line1[i] <= line1[i-1];
        line2[i] <= line2[i-1];
      end
      for (int k = 0; k < 9; k++) win_p0[k] <= win_nxt[k];
    end
  end

  // Stage p1: registered window outputs and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 9; k++) pxl_p1[k] <= '0;
    end else begin
      valid_out  <= emit_p0;
      frame_done <= emit_p0 && last_p0;
      if (emit_p0) begin
        for (int k = 0; k < 9; k++) pxl_p1[k] <= win_nxt[k];
      end
      if (accept_p0) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  assign pxl_out_00 = pxl_p1[0];
  assign pxl_out_01 = pxl_p1[1];
  assign pxl_out_02 = pxl_p1[2];
  assign pxl_out_03 = pxl_p1[3];
  assign pxl_out_04 = pxl_p1[4];
  assign pxl_out_05 = pxl_p1[5];
  assign pxl_out_06 = pxl_p1[6];
  assign pxl_out_07 = pxl_p1[7];
  assign pxl_out_08 = pxl_p1[8];

endmodule

// File: tb/tb_avgp_3x3_window_gen.sv
// Bench for avgp_3x3_window_gen: a 5x5 and a 3x3 instance checked every cycle
// against a frame-image model, plus literal window expectations.
module tb_avgp_3x3_window_gen;

  typedef logic [9*32-1:0] winp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, vin_a, vout_a, fd_a;
  logic [31:0] pin_a;
  logic [31:0] oa [9];
  logic        rst_b, vin_b, vout_b, fd_b;
  logic [31:0] pin_b;
  logic [31:0] ob [9];

  avgp_3x3_window_gen #(.DATA_WIDTH(32), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5)) dut_a (
    .clk(clk), .reset(rst_a), .valid_in(vin_a), .pixel_in(pin_a),
    .pxl_out_00(oa[0]), .pxl_out_01(oa[1]), .pxl_out_02(oa[2]),
    .pxl_out_03(oa[3]), .pxl_out_04(oa[4]), .pxl_out_05(oa[5]),
    .pxl_out_06(oa[6]), .pxl_out_07(oa[7]), .pxl_out_08(oa[8]),
    .valid_out(vout_a), .frame_done(fd_a));

  avgp_3x3_window_gen #(.DATA_WIDTH(32), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3)) dut_b (
    .clk(clk), .reset(rst_b), .valid_in(vin_b), .pixel_in(pin_b),
    .pxl_out_00(ob[0]), .pxl_out_01(ob[1]), .pxl_out_02(ob[2]),
    .pxl_out_03(ob[3]), .pxl_out_04(ob[4]), .pxl_out_05(ob[5]),
    .pxl_out_06(ob[6]), .pxl_out_07(ob[7]), .pxl_out_08(ob[8]),
    .valid_out(vout_b), .frame_done(fd_b));

  int    cmp_cnt = 0;
  int    err_cnt = 0;
  logic  chk_en = 1'b0;

  // Model state: the current frame as an image, indexed by raster position
  logic [31:0] img [2][5][5];
  int          mr [2] = '{0, 0};
  int          mc [2] = '{0, 0};
  logic        ev [2] = '{1'b0, 1'b0};
  logic        efd [2] = '{1'b0, 1'b0};
  logic [31:0] ew [2][9];
  int          mdl_str [2] = '{0, 0};
  int          dut_fd [2] = '{0, 0};
  winp_t       log_a [$];
  winp_t       log_b [$];

  task automatic chk(input string nm, input logic [287:0] got, input logic [287:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic winp_t mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Window ending at (r,c) of a frame whose pixel values are base + r*w + c
  function automatic winp_t win_at(input int base, input int r, input int c, input int w);
    winp_t x;
    for (int k = 0; k < 9; k++) x[k*32 +: 32] = 32'(base + (r - 2 + k / 3) * w + (c - 2 + k % 3));
    return x;
  endfunction

  task automatic model_step(input int d, input logic rs, input logic v, input logic [31:0] p,
                            input int w, input int h);
    ev[d] = 1'b0;
    efd[d] = 1'b0;
    if (rs) begin
      mr[d] = 0;
      mc[d] = 0;
    end else if (v) begin
      img[d][mr[d]][mc[d]] = p;
      if (mr[d] >= 2 && mc[d] >= 2) begin
        ev[d] = 1'b1;
        mdl_str[d]++;
        for (int k = 0; k < 9; k++) ew[d][k] = img[d][mr[d] - 2 + k / 3][mc[d] - 2 + k % 3];
        efd[d] = (mr[d] == h - 1) && (mc[d] == w - 1);
      end
      if (mc[d] == w - 1) begin
        mc[d] = 0;
        mr[d] = (mr[d] == h - 1) ? 0 : mr[d] + 1;
      end else begin
        mc[d] = mc[d] + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, vin_a, pin_a, 5, 5);
    model_step(1, rst_b, vin_b, pin_b, 3, 3);
  end

  task automatic compare_dut(input int d, input logic v, input logic fd, input logic [31:0] o [9]);
    winp_t x;
    chk($sformatf("valid_out dut%0d", d), 288'(v), 288'(ev[d]));
    chk($sformatf("frame_done dut%0d", d), 288'(fd), 288'(efd[d]));
    if (ev[d]) begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("pxl_out_0%0d dut%0d", k, d), 288'(o[k]), 288'(ew[d][k]));
    end
    if (v === 1'b1) begin
      for (int k = 0; k < 9; k++) x[k*32 +: 32] = o[k];
      if (d == 0) log_a.push_back(x); else log_b.push_back(x);
      if (fd === 1'b1) dut_fd[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_dut(0, vout_a, fd_a, oa);
      compare_dut(1, vout_b, fd_b, ob);
    end
  end

  task automatic px_a(input logic [31:0] p);
    @(negedge clk);
    vin_a = 1'b1;
    pin_a = p;
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      vin_a = 1'b0;
    end
  endtask

  task automatic frame_a(input int base, input bit gaps);
    for (int i = 0; i < 25; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle_a(1 + $urandom_range(0, 1));
      px_a(32'(base + i));
    end
  endtask

  task automatic all_windows(input string nm, input int s0, input int base);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s win%0d", nm, i), log_a[s0 + i], win_at(base, 2 + i / 3, 2 + i % 3, 5));
  endtask

  logic [31:0] fp [9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                         32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                         32'h41100000};

  initial begin
    int s0, m0, f0;
    rst_a = 1'b1; vin_a = 1'b0; pin_a = '0;
    rst_b = 1'b1; vin_b = 1'b0; pin_b = '0;
    @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("reset valid_out a", 288'(vout_a), 288'(0));
    chk("reset frame_done a", 288'(fd_a), 288'(0));
    chk("reset valid_out b", 288'(vout_b), 288'(0));
    for (int k = 0; k < 9; k++) chk($sformatf("reset pxl_out_0%0d a", k), 288'(oa[k]), 288'(0));
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_en = 1'b1;

    // Continuous 5x5 frame 0..24
    s0 = log_a.size(); m0 = mdl_str[0]; f0 = dut_fd[0];
    frame_a(0, 1'b0);
    idle_a(3);
    chk("t1 strobes", 288'(log_a.size() - s0), 288'(9));
    chk("t1 model strobes", 288'(mdl_str[0] - m0), 288'(9));
    chk("t1 frame_done count", 288'(dut_fd[0] - f0), 288'(1));
    chk("t1 first window", log_a[s0], mk(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chk("t1 row-wrap window", log_a[s0 + 3], mk(5, 6, 7, 10, 11, 12, 15, 16, 17));
    chk("t1 last window", log_a[s0 + 8], mk(12, 13, 14, 17, 18, 19, 22, 23, 24));

    // Same frame with random idle cycles
    s0 = log_a.size(); f0 = dut_fd[0];
    frame_a(0, 1'b1);
    idle_a(3);
    chk("t2 strobes", 288'(log_a.size() - s0), 288'(9));
    chk("t2 frame_done count", 288'(dut_fd[0] - f0), 288'(1));
    all_windows("t2", s0, 0);

    // Two frames back-to-back
    s0 = log_a.size(); f0 = dut_fd[0];
    frame_a(0, 1'b0);
    frame_a(100, 1'b0);
    idle_a(3);
    chk("t3 strobes", 288'(log_a.size() - s0), 288'(18));
    chk("t3 frame_done count", 288'(dut_fd[0] - f0), 288'(2));
    chk("t3 frame2 first window", log_a[s0 + 9], mk(100, 101, 102, 105, 106, 107, 110, 111, 112));
    all_windows("t3 f1", s0, 0);
    all_windows("t3 f2", s0 + 9, 100);

    // Reset after pixel 13 (with a valid pixel during reset), then a fresh frame
    s0 = log_a.size(); f0 = dut_fd[0];
    for (int i = 0; i <= 13; i++) px_a(32'(i));
    @(negedge clk);
    rst_a = 1'b1; vin_a = 1'b1; pin_a = 32'hDEAD;
    @(negedge clk);
    rst_a = 1'b0; vin_a = 1'b0;
    frame_a(200, 1'b0);
    idle_a(3);
    chk("t4 strobes", 288'(log_a.size() - s0), 288'(11));
    chk("t4 frame_done count", 288'(dut_fd[0] - f0), 288'(1));
    chk("t4 first post-reset window", log_a[s0 + 2], mk(200, 201, 202, 205, 206, 207, 210, 211, 212));
    all_windows("t4", s0 + 2, 200);

    // 3x3 frame of fp32 words
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vin_b = 1'b1;
      pin_b = fp[i];
    end
    @(negedge clk);
    vin_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 strobes", 288'(log_b.size()), 288'(1));
    chk("t5 model strobes", 288'(mdl_str[1]), 288'(1));
    chk("t5 frame_done count", 288'(dut_fd[1]), 288'(1));
    if (log_b.size() > 0)
      chk("t5 fp window", log_b[0], mk(fp[0], fp[1], fp[2], fp[3], fp[4], fp[5], fp[6], fp[7], fp[8]));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
